// File: rtl/wb_tag_initiator_pkg.sv
// Shared types for wb_tag_initiator: FSM state encoding, default timeout and
// the captured-response record.
package wb_tag_initiator_pkg;

    localparam int unsigned DEF_TIMEOUT = 255;
    localparam int          RSP_DAT_W   = 32;
    localparam int          RSP_TGD_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RSP  = 2'd2
    } state_t;

    // The capture register is sized at the package widths; the top casts in and out.
    typedef struct packed {
        logic [RSP_DAT_W-1:0] dat;
        logic [RSP_TGD_W-1:0] tgd;
        logic                 err;
        logic                 timeout;
    } rsp_t;

endpackage

// File: rtl/wb_tag_initiator_timer.sv
// Bus-cycle watchdog for wb_tag_initiator: cleared by load, counts enabled
// cycles and flags when the count reaches TIMEOUT.
module wb_tag_initiator_timer
    import wb_tag_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= '0;
        else if (enable && !expired)
            count <= count + 1'b1;
    end

    assign expired = (count == CNT_W'(TIMEOUT));

endmodule

// File: rtl/wb_tag_initiator.sv
// Single-outstanding classic Wishbone initiator with TGA/TGC/TGD tags.
// Optional bus watchdog enabled by defining WB_TAG_INITIATOR_TIMEOUT_EN.
module wb_tag_initiator
    import wb_tag_initiator_pkg::*;
#(
    parameter int          ADR_W   = 32,
    parameter int          DAT_W   = 32,
    parameter int          TGA_W   = 1,
    parameter int          TGC_W   = 1,
    parameter int          TGD_W   = 4,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [ADR_W-1:0]   req_adr,
    input  logic [DAT_W-1:0]   req_dat,
    input  logic [DAT_W/8-1:0] req_sel,
    input  logic [TGA_W-1:0]   req_tga,
    input  logic [TGC_W-1:0]   req_tgc,
    input  logic [TGD_W-1:0]   req_tgd,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DAT_W-1:0]   rsp_dat,
    output logic [TGD_W-1:0]   rsp_tgd,
    output logic               rsp_err,
    output logic               rsp_timeout,
    output logic [ADR_W-1:0]   i_adr,
    output logic [DAT_W-1:0]   i_dat_w,
    output logic [DAT_W/8-1:0] i_sel,
    output logic               i_we,
    output logic               i_cyc,
    output logic               i_stb,
    output logic [TGA_W-1:0]   i_tga,
    output logic [TGC_W-1:0]   i_tgc,
    output logic [TGD_W-1:0]   i_tgd_w,
    input  logic [DAT_W-1:0]   i_dat_r,
    input  logic [TGD_W-1:0]   i_tgd_r,
    input  logic               i_ack,
    input  logic               i_err
);

    state_t state;
    rsp_t   rsp_q;
    logic   term;
    logic   expired;

    assign term = i_ack | i_err;

`ifdef WB_TAG_INITIATOR_TIMEOUT_EN
    wb_tag_initiator_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clock   (clock),
        .reset   (reset),
        .load    (state == IDLE && req_valid),
        .enable  (state == BUS && !term),
        .expired (expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign expired        = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            i_adr   <= '0;
            i_dat_w <= '0;
            i_sel   <= '0;
            i_we    <= 1'b0;
            i_tga   <= '0;
            i_tgc   <= '0;
            i_tgd_w <= '0;
            rsp_q   <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    i_adr   <= req_adr;
                    i_dat_w <= req_dat;
                    i_sel   <= req_sel;
                    i_we    <= req_we;
                    i_tga   <= req_tga;
                    i_tgc   <= req_tgc;
                    i_tgd_w <= req_tgd;
                    state   <= BUS;
                end
                // A real termination on the expiry cycle wins over the watchdog.
                BUS: if (term) begin
                    rsp_q <= '{dat: RSP_DAT_W'(i_dat_r), tgd: RSP_TGD_W'(i_tgd_r),
                               err: i_err, timeout: 1'b0};
                    state <= RSP;
                end else if (expired) begin
                    rsp_q <= '{dat: '0, tgd: '0, err: 1'b1, timeout: 1'b1};
                    state <= RSP;
                end
                RSP: if (rsp_ready)
                    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign i_cyc       = (state == BUS);
    assign i_stb       = i_cyc;
    assign req_ready   = (state == IDLE) && !reset;
    assign rsp_valid   = (state == RSP);
    assign rsp_dat     = DAT_W'(rsp_q.dat);
    assign rsp_tgd     = TGD_W'(rsp_q.tgd);
    assign rsp_err     = rsp_q.err;
    assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_wb_tag_initiator.sv
// Self-checking bench for wb_tag_initiator: directed table, hand-written corner
// sequences and random transactions against a cycle-level reference model.
module tb_wb_tag_initiator;

    localparam int TO = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [31:0] req_adr = '0, req_dat = '0;
    logic [3:0]  req_sel = '0;
    logic        req_tga = 1'b0, req_tgc = 1'b0;
    logic [3:0]  req_tgd = '0;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic [3:0]  rsp_tgd;
    logic        rsp_err, rsp_timeout;
    logic [31:0] i_adr, i_dat_w, i_dat_r = '0;
    logic [3:0]  i_sel, i_tgd_w, i_tgd_r = '0;
    logic        i_we, i_cyc, i_stb, i_tga, i_tgc;
    logic        i_ack = 1'b0, i_err = 1'b0;

    wb_tag_initiator #(.TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_adr(req_adr), .req_dat(req_dat), .req_sel(req_sel),
        .req_tga(req_tga), .req_tgc(req_tgc), .req_tgd(req_tgd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_tgd(rsp_tgd), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .i_adr(i_adr), .i_dat_w(i_dat_w), .i_sel(i_sel), .i_we(i_we),
        .i_cyc(i_cyc), .i_stb(i_stb), .i_tga(i_tga), .i_tgc(i_tgc),
        .i_tgd_w(i_tgd_w), .i_dat_r(i_dat_r), .i_tgd_r(i_tgd_r),
        .i_ack(i_ack), .i_err(i_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic [31:0] adr, dat;
        logic [3:0]  sel;
        logic        tga, tgc;
        logic [3:0]  tgd;
        int          lat;      // cycle the target terminates on, 0 = never
        logic        ack, err;
        logic [31:0] dr;
        logic [3:0]  tr;
        int          rdy;      // cycles rsp_ready is held low
        logic [31:0] x_dat;
        logic [3:0]  x_tgd;
        logic        x_err, x_tmo;
    } vec_t;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Cycle on which the bus phase ends, counting the handshake cycle as 0.
    function automatic int term_cycle(input int lat);
`ifdef WB_TAG_INITIATOR_TIMEOUT_EN
        return (lat == 0 || lat > TO + 1) ? TO + 1 : lat;
`else
        return lat;
`endif
    endfunction

    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        bit tmo;
`ifdef WB_TAG_INITIATOR_TIMEOUT_EN
        tmo = (v.lat == 0 || v.lat > TO + 1);
`else
        tmo = 1'b0;
`endif
        r.x_tmo = tmo;
        r.x_err = tmo ? 1'b1 : v.err;
        r.x_dat = tmo ? 32'h0 : v.dr;
        r.x_tgd = tmo ? 4'h0 : v.tr;
        return r;
    endfunction

    function automatic vec_t mkv(input logic we, input logic [31:0] adr, dat, input logic [3:0] sel,
                                 input logic tga, tgc, input logic [3:0] tgd, input int lat,
                                 input logic ack, err, input logic [31:0] dr, input logic [3:0] tr,
                                 input int rdy, input logic [31:0] xd, input logic [3:0] xt,
                                 input logic xe);
        vec_t v;
        v.we = we; v.adr = adr; v.dat = dat; v.sel = sel; v.tga = tga; v.tgc = tgc;
        v.tgd = tgd; v.lat = lat; v.ack = ack; v.err = err; v.dr = dr; v.tr = tr;
        v.rdy = rdy; v.x_dat = xd; v.x_tgd = xt; v.x_err = xe; v.x_tmo = 1'b0;
        return v;
    endfunction

    task automatic run_txn(input vec_t v);
        int bad;
        int term;
        bit in_bus;
        @(negedge clock);
        req_valid = 1'b1; req_we = v.we; req_adr = v.adr; req_dat = v.dat; req_sel = v.sel;
        req_tga = v.tga; req_tgc = v.tgc; req_tgd = v.tgd;
        chk("req_ready_idle", req_ready, 1'b1);
        @(posedge clock);
        #1;
        req_valid = 1'b0; req_adr = $urandom; req_dat = $urandom; req_we = ~v.we;
        req_sel = 4'($urandom); req_tgd = 4'($urandom); req_tga = ~v.tga; req_tgc = ~v.tgc;
        term = term_cycle(v.lat);
        bad = 0;
        for (int k = 1; k <= term + 1; k++) begin
            @(negedge clock);
            in_bus = (k <= term);
            if (i_cyc !== in_bus || i_stb !== in_bus || rsp_valid !== !in_bus || req_ready !== 1'b0)
                bad++;
            if (in_bus && {i_we, i_adr, i_dat_w, i_sel, i_tga, i_tgc, i_tgd_w} !==
                          {v.we, v.adr, v.dat, v.sel, v.tga, v.tgc, v.tgd})
                bad++;
            if (k == v.lat) begin
                i_ack = v.ack; i_err = v.err; i_dat_r = v.dr; i_tgd_r = v.tr;
            end else begin
                i_ack = 1'b0; i_err = 1'b0; i_dat_r = $urandom; i_tgd_r = 4'($urandom);
            end
        end
        chk("bus_phase_bad_cycles", bad, 0);
        chk("rsp_fields", {rsp_dat, rsp_tgd, rsp_err, rsp_timeout},
            {v.x_dat, v.x_tgd, v.x_err, v.x_tmo});
        bad = 0;
        for (int d = 0; d < v.rdy; d++) begin
            rsp_ready = 1'b0; req_valid = 1'b1;
            i_ack = 1'($urandom); i_err = 1'($urandom); i_dat_r = $urandom;
            @(negedge clock);
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || i_cyc !== 1'b0 ||
                {rsp_dat, rsp_tgd, rsp_err, rsp_timeout} !== {v.x_dat, v.x_tgd, v.x_err, v.x_tmo})
                bad++;
        end
        if (v.rdy > 0) chk("backpressure_bad_cycles", bad, 0);
        i_ack = 1'b0; i_err = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        rsp_ready = 1'b0;
        chk("after_rsp_handshake", {rsp_valid, req_ready, i_cyc}, 3'b010);
    endtask

    vec_t tbl[6];

    initial begin
        int bad;
        vec_t v;
        tbl[0] = mkv(0, 32'h1000_0000, 32'h0, 4'hF, 0, 0, 4'h0, 2, 1, 0, 32'hDEAD_BEEF, 4'hA, 0,
                     32'hDEAD_BEEF, 4'hA, 0);
        tbl[1] = mkv(1, 32'h0000_0020, 32'h1234_5678, 4'h3, 1, 1, 4'h5, 2, 1, 0, 32'h0BAD_F00D, 4'h6, 0,
                     32'h0BAD_F00D, 4'h6, 0);
        tbl[2] = mkv(0, 32'h0000_0040, 32'h0, 4'hF, 0, 1, 4'h2, 2, 1, 0, 32'hCAFE_F00D, 4'h3, 5,
                     32'hCAFE_F00D, 4'h3, 0);
        tbl[3] = mkv(0, 32'h0000_0080, 32'h0, 4'hF, 1, 0, 4'h1, 3, 0, 1, 32'h1111_2222, 4'hC, 1,
                     32'h1111_2222, 4'hC, 1);
        tbl[4] = mkv(1, 32'h0000_00C0, 32'hA5A5_5A5A, 4'h9, 0, 0, 4'h7, 2, 1, 1, 32'h3333_4444, 4'h9, 0,
                     32'h3333_4444, 4'h9, 1);
        tbl[5] = mkv(0, 32'hFFFF_FFFC, 32'h0, 4'h1, 1, 1, 4'hF, 1, 1, 0, 32'h5566_7788, 4'hF, 2,
                     32'h5566_7788, 4'hF, 0);

        // Reset: every output low, then only req_ready rises.
        #1;
        chk("reset_outputs", {req_ready, rsp_valid, rsp_dat, rsp_tgd, rsp_err, rsp_timeout, i_adr,
                              i_dat_w, i_sel, i_we, i_cyc, i_stb, i_tga, i_tgc, i_tgd_w}, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("req_ready_after_reset", {req_ready, rsp_valid, i_cyc}, 3'b100);

        foreach (tbl[i]) run_txn(tbl[i]);

        // Spurious terminations while idle must be ignored.
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            i_ack = 1'b1; i_err = 1'(c);
            @(negedge clock);
            if (rsp_valid !== 1'b0 || i_cyc !== 1'b0 || req_ready !== 1'b1) bad++;
        end
        i_ack = 1'b0; i_err = 1'b0;
        chk("idle_spurious_ack", bad, 0);

`ifdef WB_TAG_INITIATOR_TIMEOUT_EN
        run_txn(model(mkv(0, 32'h300, 0, 4'hF, 0, 0, 0, 0, 0, 0, 32'h7777_7777, 4'h7, 0, 0, 0, 0)));
        run_txn(model(mkv(0, 32'h304, 0, 4'hF, 0, 0, 0, TO + 1, 1, 0, 32'h8888_8888, 4'h8, 0, 0, 0, 0)));
        run_txn(model(mkv(0, 32'h308, 0, 4'hF, 0, 0, 0, TO + 2, 1, 1, 32'h9999_9999, 4'h9, 2, 0, 0, 0)));
`endif

        // Hung target, then reset in the middle of the bus phase.
        @(negedge clock);
        req_valid = 1'b1; req_adr = 32'h400; req_we = 1'b0;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
`ifdef WB_TAG_INITIATOR_TIMEOUT_EN
        repeat (3) @(negedge clock);
`else
        repeat (1000) @(negedge clock);
`endif
        chk("cyc_held_hung_target", {i_cyc, i_stb}, 2'b11);
        reset = 1'b1;
        #1;
        chk("reset_mid_bus", {i_cyc, i_stb, rsp_valid, req_ready}, 4'b0000);
        @(negedge clock);
        reset = 1'b0;
        run_txn(model(mkv(0, 32'h500, 0, 4'hF, 1, 0, 4'h3, 2, 1, 0, 32'h0123_4567, 4'hB, 0, 0, 0, 0)));

        for (int n = 0; n < 40; n++) begin
            int kind;
            v.we = 1'($urandom); v.adr = $urandom; v.dat = $urandom; v.sel = 4'($urandom);
            v.tga = 1'($urandom); v.tgc = 1'($urandom); v.tgd = 4'($urandom);
`ifdef WB_TAG_INITIATOR_TIMEOUT_EN
            v.lat = $urandom_range(0, TO + 4);
`else
            v.lat = $urandom_range(1, 6);
`endif
            kind = $urandom_range(0, 2);
            v.ack = (kind != 1); v.err = (kind != 0);
            v.dr = $urandom; v.tr = 4'($urandom); v.rdy = $urandom_range(0, 3);
            run_txn(model(v));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
